// File: rtl/conv_layer_sequencer.sv
// conv_layer_sequencer: runs the 3x3 conv controller over N layers, flipping the ping-pong opcode per layer.
// Define SEQ_WATCHDOG_EN to abort and flag o_error when a layer's RUN phase exceeds TIMEOUT_CYCLES.
module conv_layer_sequencer #(
    parameter int                   LAYER_W        = 4,
    parameter int                   TIMEOUT_W      = 20,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 20'd1000000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [LAYER_W-1:0] i_numLayers,
    input  logic               i_abort,
    input  logic               i_convFinish,
    input  logic               i_initOpcode,
    output logic               o_convStart,
    output logic               o_opcode,
    output logic [LAYER_W-1:0] o_layerIdx,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_aborted,
    output logic               o_error
);
    typedef enum logic [2:0] {IDLE, LAUNCH, RUN, SWAP, DONE} state_t;

    if (TIMEOUT_CYCLES == '0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be nonzero");
    end

    state_t             state_q, state_d;
    logic [LAYER_W-1:0] count_q, count_d, idx_q, idx_d;
    logic               opcode_q, opcode_d, aborted_q, aborted_d;
    logic               conv_start_q, busy_q, done_q;
`ifdef SEQ_WATCHDOG_EN
    logic [TIMEOUT_W-1:0] wd_q, wd_d;
    logic                 error_q, error_d;
`endif

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        idx_d     = idx_q;
        opcode_d  = opcode_q;
        aborted_d = 1'b0;
`ifdef SEQ_WATCHDOG_EN
        wd_d      = wd_q;
        error_d   = error_q;
`endif
        // Abort outranks every other transition and freezes opcode/index.
        if (state_q != IDLE && i_abort) begin
            state_d   = IDLE;
            aborted_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: if (i_start && !i_abort) begin
                    count_d  = i_numLayers;
                    opcode_d = i_initOpcode;
                    idx_d    = '0;
`ifdef SEQ_WATCHDOG_EN
                    error_d  = 1'b0;
`endif
                    state_d  = (i_numLayers != '0) ? LAUNCH : DONE;
                end
                LAUNCH: begin
                    state_d = RUN;
`ifdef SEQ_WATCHDOG_EN
                    wd_d    = '0;
`endif
                end
                RUN: if (i_convFinish) begin
                    state_d = SWAP;
`ifdef SEQ_WATCHDOG_EN
                end else if (wd_q == TIMEOUT_CYCLES - TIMEOUT_W'(1)) begin
                    error_d   = 1'b1;
                    aborted_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    wd_d = wd_q + TIMEOUT_W'(1);
`endif
                end
                SWAP: begin
                    opcode_d = ~opcode_q;
                    if (idx_q == count_q - LAYER_W'(1)) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + LAYER_W'(1);
                        state_d = LAUNCH;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q      <= IDLE;
            count_q      <= '0;
            idx_q        <= '0;
            opcode_q     <= 1'b0;
            aborted_q    <= 1'b0;
            conv_start_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
            wd_q         <= '0;
            error_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            idx_q        <= idx_d;
            opcode_q     <= opcode_d;
            aborted_q    <= aborted_d;
            conv_start_q <= (state_d == LAUNCH);
            busy_q       <= (state_d != IDLE);
            done_q       <= (state_d == DONE);
`ifdef SEQ_WATCHDOG_EN
            wd_q         <= wd_d;
            error_q      <= error_d;
`endif
        end
    end

    assign o_convStart = conv_start_q;
    assign o_opcode    = opcode_q;
    assign o_layerIdx  = idx_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_aborted   = aborted_q;
`ifdef SEQ_WATCHDOG_EN
    assign o_error     = error_q;
`else
    assign o_error     = 1'b0;
`endif
endmodule

// File: tb/tb_conv_layer_sequencer.sv
// tb_conv_layer_sequencer: directed test-plan scenarios plus randomized traffic against a cycle-level reference model.
module tb_conv_layer_sequencer;
    localparam int LW = 4;
    localparam int TMO = 100;

    logic          i_clk = 1'b0, i_reset = 1'b0, i_start = 1'b0, i_abort = 1'b0;
    logic          i_convFinish = 1'b0, i_initOpcode = 1'b0;
    logic [LW-1:0] i_numLayers = '0;
    logic          o_convStart, o_opcode, o_busy, o_done, o_aborted, o_error;
    logic [LW-1:0] o_layerIdx;
    int            checks = 0, fails = 0;

    conv_layer_sequencer #(.LAYER_W(LW), .TIMEOUT_W(20), .TIMEOUT_CYCLES(20'd100)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_numLayers(i_numLayers),
        .i_abort(i_abort), .i_convFinish(i_convFinish), .i_initOpcode(i_initOpcode),
        .o_convStart(o_convStart), .o_opcode(o_opcode), .o_layerIdx(o_layerIdx),
        .o_busy(o_busy), .o_done(o_done), .o_aborted(o_aborted), .o_error(o_error)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected outputs for the cycle after each edge.
    logic e_start = 0, e_done = 0, e_abort = 0, e_busy = 0, e_op = 0, e_err = 0;
    int   e_idx = 0, m_layers = 0, m_wd = 0;
    bit   waiting = 0, swapping = 0;

    always @(posedge i_clk or negedge i_reset) begin : model
        bit ns, nd, na;
        if (!i_reset) begin
            {e_start, e_done, e_abort, e_busy, e_op, e_err} = '0;
            e_idx = 0; m_layers = 0; m_wd = 0; waiting = 0; swapping = 0;
        end else begin
            ns = 0; nd = 0; na = 0;
            if (!e_busy) begin
                if (i_start && !i_abort) begin
                    m_layers = int'(i_numLayers); e_op = i_initOpcode; e_idx = 0; e_err = 0;
                    if (m_layers == 0) nd = 1; else ns = 1;
                end
            end else if (i_abort) begin
                na = 1; waiting = 0; swapping = 0;
            end else if (e_start) begin
                waiting = 1; m_wd = 0;
            end else if (swapping) begin
                swapping = 0; e_op = ~e_op;
                if (e_idx + 1 == m_layers) nd = 1;
                else begin e_idx++; ns = 1; end
            end else if (waiting) begin
                if (i_convFinish) begin
                    waiting = 0; swapping = 1;
                end else begin
                    m_wd++;
`ifdef SEQ_WATCHDOG_EN
                    if (m_wd == TMO) begin waiting = 0; e_err = 1; na = 1; end
`endif
                end
            end
            e_start = ns; e_done = nd; e_abort = na;
            e_busy  = ns || nd || waiting || swapping;
        end
    end

    always @(negedge i_clk) if (i_reset) begin
        chk("convStart", o_convStart, e_start);
        chk("done", o_done, e_done);
        chk("aborted", o_aborted, e_abort);
        chk("busy", o_busy, e_busy);
        chk("opcode", o_opcode, e_op);
        chk("layerIdx", o_layerIdx, e_idx);
        chk("error", o_error, e_err);
    end

    int log_op[$], log_idx[$];
    int done_cnt = 0, busy_cnt = 0;

    always @(negedge i_clk) if (i_reset) begin
        if (o_convStart) begin log_op.push_back(int'(o_opcode)); log_idx.push_back(int'(o_layerIdx)); end
        done_cnt += int'(o_done);
        busy_cnt += int'(o_busy);
    end

    task automatic clear_logs();
        log_op.delete(); log_idx.delete(); done_cnt = 0; busy_cnt = 0;
    endtask

    task automatic tick();
        @(posedge i_clk); #2;
    endtask

    task automatic start(input int n, input logic op);
        i_numLayers = LW'(n); i_initOpcode = op; i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_launch();
        int n = 0;
        while (o_convStart !== 1'b1 && n < 50) begin tick(); n++; end
        checks++;
        if (n == 50) begin fails++; $display("FAIL launch_timeout: no o_convStart within 50 cycles, required 1"); end
    endtask

    task automatic run_finish(input int delay);
        wait_launch();
        repeat (delay) tick();
        i_convFinish = 1'b1;
        tick();
        i_convFinish = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_busy", o_busy, 0);
        chk("rst_opcode", o_opcode, 0);
        chk("rst_idx", o_layerIdx, 0);
        chk("rst_error", o_error, 0);
        i_reset = 1'b1;
        tick();

        clear_logs();
        start(3, 1'b0);
        repeat (3) run_finish(2);
        tick();
        chk("done_2_after_finish", o_done, 1);
        tick();
        chk("busy_after_done", o_busy, 0);
        chk("final_opcode", o_opcode, 1);
        chk("final_idx", o_layerIdx, 2);
        repeat (2) tick();
        chk("launch_count3", log_op.size(), 3);
        if (log_op.size() == 3) begin
            chk("op_l0", log_op[0], 0); chk("op_l1", log_op[1], 1); chk("op_l2", log_op[2], 0);
            chk("idx_l0", log_idx[0], 0); chk("idx_l1", log_idx[1], 1); chk("idx_l2", log_idx[2], 2);
        end
        chk("done_count3", done_cnt, 1);

        clear_logs();
        start(0, 1'b0);
        chk("zero_done", o_done, 1);
        chk("zero_convStart", o_convStart, 0);
        repeat (2) tick();
        chk("zero_busy_cycles", busy_cnt, 1);
        chk("zero_launches", log_op.size(), 0);
        chk("zero_done_count", done_cnt, 1);

        clear_logs();
        start(4, 1'b0);
        run_finish(3);
        wait_launch();
        repeat (2) tick();
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        chk("abort_pulse", o_aborted, 1);
        chk("abort_idx", o_layerIdx, 1);
        chk("abort_busy", o_busy, 0);
        repeat (10) tick();
        chk("abort_launches", log_op.size(), 2);
        chk("abort_no_done", done_cnt, 0);

        clear_logs();
        start(2, 1'b1);
        i_start = 1'b1; i_numLayers = LW'(5); i_convFinish = 1'b1;
        tick();
        i_start = 1'b0; i_convFinish = 1'b0;
        chk("stray_idx", o_layerIdx, 0);
        chk("stray_busy", o_busy, 1);
        chk("stray_no_restart", o_convStart, 0);
        repeat (3) tick();
        i_convFinish = 1'b1;
        tick();
        i_convFinish = 1'b0;
        run_finish(1);
        repeat (3) tick();
        chk("stray_launches", log_op.size(), 2);
        if (log_op.size() == 2) begin
            chk("stray_idx_l1", log_idx[1], 1); chk("stray_op_l1", log_op[1], 0);
        end
        chk("stray_done", done_cnt, 1);

        start(3, 1'b1);
        run_finish(1);
        run_finish(1);
        wait_launch();
        repeat (2) tick();
        chk("pre_reset_idx", o_layerIdx, 2);
        chk("pre_reset_op", o_opcode, 1);
        #1 i_reset = 1'b0;
        #1;
        chk("async_busy", o_busy, 0);
        chk("async_idx", o_layerIdx, 0);
        chk("async_op", o_opcode, 0);
        chk("async_convStart", o_convStart, 0);
        chk("async_done", o_done, 0);
        chk("async_aborted", o_aborted, 0);
        repeat (2) tick();
        i_reset = 1'b1;
        tick();
        start(1, 1'b1);
        chk("restart_convStart", o_convStart, 1);
        chk("restart_idx", o_layerIdx, 0);
        chk("restart_op", o_opcode, 1);
        run_finish(1);
        repeat (3) tick();

`ifdef SEQ_WATCHDOG_EN
        begin
            int n = 0;
            start(2, 1'b0);
            while (o_aborted !== 1'b1 && n < 300) begin tick(); n++; end
            chk("wd_cycles", n, TMO + 1);
            chk("wd_error", o_error, 1);
            tick();
            chk("wd_error_sticky", o_error, 1);
            start(2, 1'b0);
            chk("wd_error_cleared", o_error, 0);
            repeat (TMO) tick();
            i_convFinish = 1'b1;
            tick();
            i_convFinish = 1'b0;
            chk("wd_edge_no_error", o_error, 0);
            chk("wd_edge_busy", o_busy, 1);
            tick();
            chk("wd_edge_launch", o_convStart, 1);
            chk("wd_edge_idx", o_layerIdx, 1);
            run_finish(1);
            repeat (3) tick();
        end
`endif

        for (int c = 0; c < 3000; c++) begin
            i_start      = ($urandom_range(0, 9) == 0);
            i_numLayers  = LW'($urandom_range(0, 4));
            i_initOpcode = 1'($urandom_range(0, 1));
            i_abort      = ($urandom_range(0, 79) == 0);
            i_convFinish = (o_busy && $urandom_range(0, 5) == 0) || ($urandom_range(0, 39) == 0);
            tick();
        end
        {i_start, i_abort, i_convFinish} = '0;
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
